vexp_seq: RTL and testbench

- Sequencer that lets the single shared vexp (FP16 exponential) unit process whole vectors.
- Accepts one LANES-wide FP16 vector per transaction and issues the elements to the unit one per cycle, in lane order.
- Collects the in-order results back into a vector and presents it downstream with a valid/ready handshake.
- Sits between the vector issue stage and the vexp unit; the vexp unit returns results in issue order.

---
 rtl/vexp_seq_if.sv | 39 +++
 rtl/vexp_seq.sv | 123 ++++++++++++
 tb/tb_vexp_seq.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vexp_seq_if.sv
// Handshake bundle between vexp_seq, the vector issue stage, the downstream consumer and the vexp unit.
// The in_mask lane enable exists only when VEXP_SEQ_MASK_EN is defined.
interface vexp_seq_if #(
  parameter int LANES = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [16*LANES-1:0]   in_vec;
`ifdef VEXP_SEQ_MASK_EN
  logic [LANES-1:0]      in_mask;
`endif
  logic                  out_valid;
  logic                  out_ready;
  logic [16*LANES-1:0]   out_vec;
  logic                  exp_req_valid;
  logic                  exp_req_ready;
  logic [15:0]           exp_req_operand;
  logic                  exp_resp_valid;
  logic [15:0]           exp_resp_data;
  logic                  exp_resp_ready;

  // Sequencer view.
  modport master (
`ifdef VEXP_SEQ_MASK_EN
    input  in_mask,
`endif
    input  in_valid, in_vec, out_ready, exp_req_ready, exp_resp_valid, exp_resp_data,
    output in_ready, out_valid, out_vec, exp_req_valid, exp_req_operand, exp_resp_ready
  );

  // Environment view: issue stage, consumer and vexp unit.
  modport slave (
`ifdef VEXP_SEQ_MASK_EN
    output in_mask,
`endif
    output in_valid, in_vec, out_ready, exp_req_ready, exp_resp_valid, exp_resp_data,
    input  in_ready, out_valid, out_vec, exp_req_valid, exp_req_operand, exp_resp_ready
  );
endinterface

// File: rtl/vexp_seq.sv
// Feeds one LANES-wide FP16 vector through the shared vexp unit element by element and reassembles
// the in-order results. Optional lane masking: define VEXP_SEQ_MASK_EN.
module vexp_seq #(
  parameter int LANES           = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic       CLK,
  input  logic       nRST,
  vexp_seq_if.master bus,
  output logic       busy,
  output logic       err
);
  localparam int IW = $clog2(LANES + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int LW = $clog2(LANES);
  localparam logic [IW-1:0] IDX_END = IW'(LANES);
  localparam logic [OW-1:0] OUT_MAX = OW'(MAX_OUTSTANDING);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]             state;
  logic [LANES-1:0][15:0] op_buf;
  logic [LANES-1:0][15:0] res_buf;
  logic [IW-1:0]          issue_idx, ret_idx;
  logic [IW-1:0]          issue_next, ret_next, first_idx;
  logic [OW-1:0]          outstanding;
  logic [LANES-1:0]       lane_en, in_en;
  logic                   accept, req_hs, resp_ok, stray;

  // First enabled lane at or above 'from'; IDX_END when none remain.
  function automatic logic [IW-1:0] next_en(input logic [IW-1:0] from, input logic [LANES-1:0] en);
    next_en = IDX_END;
    for (int i = LANES - 1; i >= 0; i--)
      if (i >= int'(from) && en[i]) next_en = IW'(i);
  endfunction

`ifdef VEXP_SEQ_MASK_EN
  logic [LANES-1:0] mask_q;
  assign lane_en = mask_q;
  assign in_en   = bus.in_mask;
`else
  assign lane_en = '1;
  assign in_en   = '1;
`endif

  assign bus.in_ready        = (state == IDLE);
  assign bus.out_valid       = (state == DONE);
  assign bus.out_vec         = res_buf;
  assign bus.exp_resp_ready  = (state == ISSUE) || (state == DRAIN);
  assign bus.exp_req_valid   = (state == ISSUE) && (issue_idx < IDX_END) && (outstanding < OUT_MAX);
  assign bus.exp_req_operand = (issue_idx < IDX_END) ? op_buf[issue_idx[LW-1:0]] : 16'h0000;
  assign busy                = (state != IDLE);

  assign accept     = bus.in_valid && (state == IDLE);
  assign req_hs     = bus.exp_req_valid && bus.exp_req_ready;
  // A response with nothing in flight is dropped rather than written to an arbitrary lane.
  assign resp_ok    = bus.exp_resp_valid && bus.exp_resp_ready && (outstanding != '0);
  assign stray      = bus.exp_resp_valid && (!bus.exp_resp_ready || (outstanding == '0));
  assign issue_next = next_en(issue_idx + IW'(1), lane_en);
  assign ret_next   = next_en(ret_idx + IW'(1), lane_en);
  assign first_idx  = next_en('0, in_en);

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      // NOTE: the lane buffers are plain registers with defined reset contents, not a RAM.
      op_buf      <= '0;
      res_buf     <= '0;
      issue_idx   <= '0;
      ret_idx     <= '0;
      outstanding <= '0;
      err         <= 1'b0;
`ifdef VEXP_SEQ_MASK_EN
      mask_q      <= '0;
`endif
    end else begin
      if (stray) err <= 1'b1;

      if (req_hs) issue_idx <= issue_next;
      if (resp_ok) begin
        res_buf[ret_idx[LW-1:0]] <= bus.exp_resp_data;
        ret_idx                  <= ret_next;
      end

      case ({req_hs, resp_ok})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (accept) begin
            op_buf      <= bus.in_vec;
            // Masked lanes pass their operand through, so results start as a copy of the input.
            res_buf     <= bus.in_vec;
            issue_idx   <= first_idx;
            ret_idx     <= first_idx;
            outstanding <= '0;
`ifdef VEXP_SEQ_MASK_EN
            mask_q      <= bus.in_mask;
`endif
            state       <= (first_idx == IDX_END) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (resp_ok && ret_next == IDX_END)         state <= DONE;
          else if (req_hs && issue_next == IDX_END)   state <= DRAIN;
        end
        DRAIN: begin
          if (resp_ok && ret_next == IDX_END) state <= DONE;
        end
        default: begin
          if (bus.out_ready) state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_vexp_seq.sv
// Directed bench for vexp_seq: a behavioural vexp unit with programmable latency and ready pattern,
// plus a scoreboard queue of expected result vectors.
module tb_vexp_seq;
  localparam int LANES   = 16;
  localparam int MAX_OUT = 4;
  localparam int VW      = 16 * LANES;

  typedef logic [VW-1:0] vec_t;
  typedef struct packed {
    logic [15:0] data;
    int          due;
  } resp_t;

  logic CLK = 1'b0;
  logic nRST;
  logic busy, err;

  vexp_seq_if #(.LANES(LANES)) bus ();

  vexp_seq #(.LANES(LANES), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus),
    .busy (busy),
    .err  (err)
  );

  always #5 CLK = ~CLK;

  int    n_cmp = 0;
  int    n_bad = 0;
  vec_t  exp_q[$];
  vec_t  last_exp = '0;

  // Unit model state.
  resp_t       pq[$];
  int          cyc = 0;
  int          lat = 3;
  bit          pat_en = 0;
  int          pat_idx = 0;
  int          pat[4] = '{1, 0, 0, 1};
  bit          stray_inj = 0;
  bit          req_pend = 0, resp_pend = 0, stall_pend = 0;
  logic [15:0] req_op, stall_op;
  int          req_cnt = 0, cap_viol = 0, stall_viol = 0, stall_seen = 0, max_out = 0;

  // Behavioural stand-in for the exponential: exact for the two FP16 values the plan names.
  function automatic logic [15:0] fake_exp(input logic [15:0] x);
    case (x)
      16'h3C00: return 16'h4170;
      16'h0000: return 16'h3C00;
      default:  return {x[7:0], x[15:8]} ^ 16'h0F0F;
    endcase
  endfunction

  task automatic check(input string tag, input vec_t obs, input vec_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // vexp unit: all decisions on the falling edge, handshakes complete on the next rising edge.
  always @(negedge CLK) begin
    cyc++;
    if (!nRST) begin
      pq.delete();
      req_pend   = 0;
      resp_pend  = 0;
      stall_pend = 0;
      bus.exp_resp_valid = 1'b0;
      bus.exp_resp_data  = 16'h0000;
      bus.exp_req_ready  = 1'b1;
    end else begin
      if (resp_pend) void'(pq.pop_front());
      if (req_pend) pq.push_back('{data: fake_exp(req_op), due: cyc + lat - 1});
      if (stall_pend && !(bus.exp_req_valid === 1'b1 && bus.exp_req_operand === stall_op))
        stall_viol++;
      if (pq.size() > max_out) max_out = pq.size();
      if (pq.size() >= MAX_OUT && bus.exp_req_valid === 1'b1) cap_viol++;

      bus.exp_req_ready = pat_en ? (pat[pat_idx % 4] == 1) : 1'b1;
      pat_idx++;
      req_pend   = bus.exp_req_valid && bus.exp_req_ready;
      req_op     = bus.exp_req_operand;
      stall_pend = bus.exp_req_valid && !bus.exp_req_ready;
      stall_op   = bus.exp_req_operand;
      if (req_pend) req_cnt++;
      if (stall_pend) stall_seen++;

      if (stray_inj) begin
        bus.exp_resp_valid = 1'b1;
        bus.exp_resp_data  = 16'hDEAD;
        resp_pend          = 0;
      end else if (pq.size() > 0 && cyc >= pq[0].due) begin
        bus.exp_resp_valid = 1'b1;
        bus.exp_resp_data  = pq[0].data;
        resp_pend          = bus.exp_resp_ready;
      end else begin
        bus.exp_resp_valid = 1'b0;
        bus.exp_resp_data  = 16'h0000;
        resp_pend          = 0;
      end
    end
  end

  // Drives one vector and pushes its expected result; returns on the falling edge after acceptance.
  task automatic send(input vec_t v, input logic [LANES-1:0] m);
    vec_t e;
    int   n = 0;
    for (int i = 0; i < LANES; i++)
      e[16*i +: 16] = m[i] ? fake_exp(v[16*i +: 16]) : v[16*i +: 16];
    exp_q.push_back(e);
    bus.in_vec   = v;
`ifdef VEXP_SEQ_MASK_EN
    bus.in_mask  = m;
`endif
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("accept_bound", vec_t'(bus.in_ready), vec_t'(1));
    @(negedge CLK);
    bus.in_valid = 1'b0;
  endtask

  // Waits for out_valid (cycle index counted from the accept cycle), checks it, then takes it.
  task automatic recv(input string tag, input int want_lat);
    int   n = 1;
    vec_t e;
    while (bus.out_valid !== 1'b1 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_valid"}, vec_t'(bus.out_valid), vec_t'(1));
    if (want_lat > 0) check({tag, "_latency"}, vec_t'(n), vec_t'(want_lat));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    last_exp = e;
    check({tag, "_vec"}, bus.out_vec, e);
    bus.out_ready = 1'b1;
    @(negedge CLK);
    bus.out_ready = 1'b0;
    check({tag, "_in_ready_after"}, vec_t'({bus.in_ready, bus.out_valid}), vec_t'(2'b10));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v_alt, v_seq, v_rst, v_one;
    int   base, n;

    for (int i = 0; i < LANES; i++) begin
      v_alt[16*i +: 16] = (i % 2 == 0) ? 16'h3C00 : 16'h0000;
      v_seq[16*i +: 16] = 16'(16'h2000 + 37 * i);
      v_rst[16*i +: 16] = 16'(16'h5100 + 3 * i);
      v_one[16*i +: 16] = 16'h3C00;
    end

    bus.in_valid  = 1'b0;
    bus.in_vec    = '0;
    bus.out_ready = 1'b0;
`ifdef VEXP_SEQ_MASK_EN
    bus.in_mask   = '1;
`endif
    nRST = 1'b0;
    repeat (3) @(negedge CLK);

    // Reset values.
    check("rst_in_ready", vec_t'(bus.in_ready), vec_t'(1));
    check("rst_flags", vec_t'({bus.out_valid, bus.exp_req_valid, bus.exp_resp_ready, busy, err}), vec_t'(0));
    check("rst_operand", vec_t'(bus.exp_req_operand), vec_t'(0));
    check("rst_out_vec", bus.out_vec, '0);
    nRST = 1'b1;
    @(negedge CLK);

    // Alternating 1.0 / 0.0, latency 3, unit always ready.
    lat = 3;
    send(v_alt, '1);
    check("busy_active", vec_t'(busy), vec_t'(1));
    recv("alt", LANES + 3 + 1);

    // Latency 8 exercises the outstanding cap.
    lat = 8;
    max_out = 0;
    send(v_seq, '1);
    recv("lat8", -1);
    check("lat8_cap_viol", vec_t'(cap_viol), vec_t'(0));
    check("lat8_cap_reached", vec_t'(max_out), vec_t'(MAX_OUT));

    // Request stalls 1,0,0,1 and a held-off consumer.
    lat = 3;
    pat_en = 1;
    stall_seen = 0;
    send(v_seq ^ {LANES{16'h0A0A}}, '1);
    n = 1;
    while (bus.out_valid !== 1'b1 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      check("hold_out_vec", bus.out_vec, exp_q[0]);
      check("hold_in_ready", vec_t'({bus.in_ready, bus.out_valid}), vec_t'(2'b01));
      @(negedge CLK);
    end
    recv("stall", -1);
    pat_en = 0;
    check("stall_operand_stable", vec_t'(stall_viol), vec_t'(0));
    check("stall_exercised", vec_t'(stall_seen > 0), vec_t'(1));

    // Stray response while idle.
    check("err_clean", vec_t'(err), vec_t'(0));
    stray_inj = 1;
    repeat (2) @(negedge CLK);
    check("stray_resp_ready", vec_t'(bus.exp_resp_ready), vec_t'(0));
    stray_inj = 0;
    repeat (4) @(negedge CLK);
    check("stray_err_sticky", vec_t'(err), vec_t'(1));
    check("stray_out_vec", bus.out_vec, last_exp);

    // Reset after three lanes issued, then a fresh vector.
    base = req_cnt;
    send(v_rst, '1);
    n = 0;
    while (req_cnt - base < 3 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("rst_mid_reached", vec_t'(req_cnt - base >= 3), vec_t'(1));
    nRST = 1'b0;
    void'(exp_q.pop_back());
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    check("rst_mid_state", vec_t'({bus.in_ready, bus.out_valid, busy, err}), vec_t'(4'b1000));
    send(v_alt ^ {LANES{16'h0100}}, '1);
    recv("after_rst", LANES + 3 + 1);

`ifdef VEXP_SEQ_MASK_EN
    base = req_cnt;
    send(v_one, 16'h0005);
    recv("mask5", -1);
    check("mask5_requests", vec_t'(req_cnt - base), vec_t'(2));
    send(v_seq, 16'h0000);
    recv("mask0", 1);
`else
    send(v_one, '1);
    recv("ones", LANES + 3 + 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
